timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel timer/interrupt peripheral on the CPU's memory-mapped I/O bus. It replaces the single fixed 32-bit timer with NUM_TIMERS independent channels, each with:
- a reload value
- a prescaler
- periodic or one-shot mode
- a write-1-to-clear pending flag

A free-running systick and a global pending summary sit above the channels, and the block drives one combined interrupt request to the CPU, gated while the CPU must not be interrupted.

## Interface
Parameters:
- NUM_TIMERS, 2 — number of timer channels (1..8)
- CNT_W, 32 — counter/reload width (8..32)
- BASE_ADDR, 32'h4000_0000 — byte address of channel 0

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset (sampled on posedge clk)
- rd  in  1  read strobe
- wr  in  1  write strobe
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irq_block  in  1  1 = suppress irqout (kernel mode / control-transfer in flight)
- irq_vec  out  NUM_TIMERS  per-channel pending & irq_en
- irqout  out  1  |irq_vec & ~irq_block

## Operation
- Register map:
  - Channel i occupies BASE_ADDR + 0x10*i:
    - +0x0 RELOAD (RW)
    - +0x4 COUNT (RW)
    - +0x8 CTRL (RW)
    - +0xC STATUS (bit0 pending; write 1 clears, write 0 no effect)
  - Global block at G = BASE_ADDR + 0x10*NUM_TIMERS:
    - G+0x0 SYSTICK (RO, 32-bit)
    - G+0x4 PEND_SUM (bit i = channel i pending; write 1 to bit i clears it)
- CTRL fields:
  - bit0 enable
  - bit1 irq_en
  - bit2 mode (0 periodic, 1 one-shot)
  - bits[15:8] presc
- Width rules:
  - RELOAD/COUNT writes take wdata[CNT_W-1:0].
  - Reads are zero-extended to 32 bits.
  - Unused CTRL bits read 0.
- Prescaler:
  - Per-channel 8-bit counter; a tick fires on the cycle it equals presc, after which it returns to 0.
  - presc=0 gives a tick every cycle.
  - The prescaler is cleared by any CTRL write and holds at 0 while enable=0.
- Counting:
  - On a tick with enable=1, COUNT increments.
  - When COUNT is all-ones on a tick (terminal):
    - COUNT <= RELOAD.
    - pending <= 1.
    - In one-shot mode, enable <= 0.
  - Terminal count always sets pending. irq_en only gates irq_vec and irqout.
- Bus:
  - rdata = 0 when rd=0 or addr is unmapped.
  - Writes to unmapped addresses and to SYSTICK are ignored.
  - Only full-word access is supported.
- SYSTICK increments every cycle and wraps at 2^32.
- Simultaneous events:
  - A CPU write to COUNT or CTRL in the same cycle as a tick: the write wins and the tick is discarded for that register.
  - A pending set and a W1C clear in the same cycle: set wins.
  - A RELOAD write on a terminal cycle: the old RELOAD is loaded.
- Reset values:
  - All RELOAD, COUNT, CTRL, pending, prescalers and SYSTICK are 0.
  - irq_vec = 0 and irqout = 0.

## Timing
- All register updates occur on posedge clk. Read data is combinational from current register state (same-cycle read, zero wait states).
- A write is visible on rdata the cycle after the write edge.
- Terminal tick at edge N: pending and the COUNT reload are visible after edge N, and irq_vec/irqout assert in cycle N+1.
- irqout follows irq_block combinationally with no added latency.
- Reset asserted mid-count returns every register to 0 at that edge. Nothing counts while reset is high.

## Structure
- Shared package timer_pkg holds:
  - register offsets (OFF_RELOAD, OFF_COUNT, OFF_CTRL, OFF_STATUS, OFF_SYSTICK, OFF_PEND_SUM)
  - CTRL bit positions
  - a ctrl_t packed struct
- Sub-module timer_channel, instantiated NUM_TIMERS times via generate, contains:
  - the prescaler
  - COUNT/RELOAD/CTRL/pending registers
  - a local write-enable decode
- The top level holds address decode, the rdata mux, SYSTICK, PEND_SUM and the irq combine.

## Test plan
- Reset: drive reset for 2 cycles -> every readable register reads 0, irqout=0. Then SYSTICK reads 1 in the first cycle after deassertion.
- Periodic, CNT_W=32, presc=0:
  - Stimulus: RELOAD=COUNT=0xFFFF_FFFD, then CTRL=0x3.
  - Required: COUNT reads FE, FF, FD on the next three cycles; pending=1 and irqout=1 from the cycle after the third edge; pattern repeats every 3 cycles.
- One-shot with presc=2:
  - Stimulus: COUNT=0xFFFF_FFFF, CTRL=0x0207.
  - Required: terminal after 3 cycles; enable reads 0; COUNT holds RELOAD thereafter.
- Clearing and gating:
  - W1C on STATUS in the same cycle as a terminal tick -> pending stays 1.
  - A later W1C -> pending=0, irqout=0.
  - With irq_block=1 and pending=1 -> irqout=0 while irq_vec=1.
- Write collision: COUNT write of 0x10 on a tick cycle -> COUNT reads 0x10, not 0x11 or the incremented old value.
- Parameter sweep:
  - NUM_TIMERS=4, CNT_W=8: channel 3 at BASE+0x30 wraps 0xFF→RELOAD.
  - PEND_SUM at BASE+0x44 reads 0x8.
  - A write to BASE+0x50 is ignored and reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL layout and
// the packed control-register type used by every channel.
package timer_pkg;

    localparam logic [3:0] OFF_RELOAD   = 4'h0;
    localparam logic [3:0] OFF_COUNT    = 4'h4;
    localparam logic [3:0] OFF_CTRL     = 4'h8;
    localparam logic [3:0] OFF_STATUS   = 4'hC;
    localparam logic [3:0] OFF_SYSTICK  = 4'h0;
    localparam logic [3:0] OFF_PEND_SUM = 4'h4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_MODE_BIT   = 2;
    localparam int CTRL_PRESC_LSB  = 8;

    typedef struct packed {
        logic [7:0] presc;
        logic       mode;
        logic       irq_en;
        logic       enable;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                        = '0;
        w[CTRL_EN_BIT]           = c.enable;
        w[CTRL_IRQ_EN_BIT]       = c.irq_en;
        w[CTRL_MODE_BIT]         = c.mode;
        w[CTRL_PRESC_LSB +: 8]   = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Memory-mapped I/O bus between the CPU and the timer bank.
interface timer_bank_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter with reload, CTRL and the
// pending flag, plus decode of writes aimed at this channel's window.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        sel,
    input  logic [3:0]  off,
    input  logic [31:0] wdata,
    input  logic        pend_clr_ext,
    output logic [31:0] rdata,
    output logic        pending,
    output logic        irq
);

    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] count;
    ctrl_t            ctrl;
    logic [7:0]       presc_cnt;

    logic wr_reload, wr_count, wr_ctrl, wr_status;
    logic tick, terminal;
    logic unused_bits;

    assign wr_reload = wr & sel & (off == OFF_RELOAD);
    assign wr_count  = wr & sel & (off == OFF_COUNT);
    assign wr_ctrl   = wr & sel & (off == OFF_CTRL);
    assign wr_status = wr & sel & (off == OFF_STATUS);

    assign tick     = ctrl.enable & (presc_cnt == ctrl.presc);
    assign terminal = tick & (&count);

    always_ff @(posedge clk) begin
        if (reset) begin
            reload    <= '0;
            count     <= '0;
            ctrl      <= '0;
            presc_cnt <= '0;
            pending   <= 1'b0;
        end else begin
            if (wr_ctrl || !ctrl.enable || tick)
                presc_cnt <= '0;
            else
                presc_cnt <= presc_cnt + 8'd1;

            if (wr_reload)
                reload <= wdata[CNT_W-1:0];

            // CPU write beats a same-cycle tick; terminal loads the pre-write RELOAD
            if (wr_count)
                count <= wdata[CNT_W-1:0];
            else if (terminal)
                count <= reload;
            else if (tick)
                count <= count + CNT_W'(1);

            if (wr_ctrl) begin
                ctrl.enable <= wdata[CTRL_EN_BIT];
                ctrl.irq_en <= wdata[CTRL_IRQ_EN_BIT];
                ctrl.mode   <= wdata[CTRL_MODE_BIT];
                ctrl.presc  <= wdata[CTRL_PRESC_LSB +: 8];
            end else if (terminal && ctrl.mode) begin
                ctrl.enable <= 1'b0;
            end

            if (terminal)
                pending <= 1'b1;
            else if ((wr_status && wdata[0]) || pend_clr_ext)
                pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_RELOAD: rdata = 32'(reload);
            OFF_COUNT:  rdata = 32'(count);
            OFF_CTRL:   rdata = ctrl_to_word(ctrl);
            OFF_STATUS: rdata = {31'b0, pending};
            default:    rdata = '0;
        endcase
    end

    assign irq         = pending & ctrl.irq_en;
    assign unused_bits = ^wdata;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer peripheral: address decode, read mux, free-running
// systick, pending summary and the gated interrupt request.
module timer_bank
    import timer_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_bank_if.slave           bus,
    input  logic                  irq_block,
    output logic [NUM_TIMERS-1:0] irq_vec,
    output logic                  irqout
);

    logic [31:0]           off;
    logic [27:0]           blk;
    logic                  aligned;
    logic                  glb_sel;
    logic                  pend_sum_wr;
    logic [NUM_TIMERS-1:0] ch_sel;
    logic [NUM_TIMERS-1:0] pend_vec;
    logic [31:0]           ch_rdata [NUM_TIMERS];
    logic [31:0]           systick;
    logic [31:0]           rd_mux;

    assign off         = bus.addr - BASE_ADDR;
    assign blk         = off[31:4];
    assign aligned     = (off[1:0] == 2'b00);
    assign glb_sel     = aligned & (blk == 28'(NUM_TIMERS));
    assign pend_sum_wr = bus.wr & glb_sel & (off[3:0] == OFF_PEND_SUM);

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        assign ch_sel[i] = aligned & (blk == 28'(i));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr           (bus.wr),
            .sel          (ch_sel[i]),
            .off          (off[3:0]),
            .wdata        (bus.wdata),
            .pend_clr_ext (pend_sum_wr & bus.wdata[i]),
            .rdata        (ch_rdata[i]),
            .pending      (pend_vec[i]),
            .irq          (irq_vec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            systick <= '0;
        else
            systick <= systick + 32'd1;
    end

    always_comb begin
        rd_mux = '0;
        if (bus.rd) begin
            if (glb_sel) begin
                case (off[3:0])
                    OFF_SYSTICK:  rd_mux = systick;
                    OFF_PEND_SUM: rd_mux = 32'(pend_vec);
                    default:      rd_mux = '0;
                endcase
            end
            for (int i = 0; i < NUM_TIMERS; i++)
                if (ch_sel[i])
                    rd_mux = ch_rdata[i];
        end
    end

    assign bus.rdata = rd_mux;
    assign irqout    = (|irq_vec) & ~irq_block;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed checks plus randomized channel runs
// compared against a closed-form model of tick and terminal timing.
module tb_timer_bank;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq_block = 1'b0;
    logic [1:0] irq_vec_a;
    logic       irqout_a;
    logic [3:0] irq_vec_b;
    logic       irqout_b;

    timer_bank_if bus_a ();
    timer_bank_if bus_b ();

    timer_bank #(.NUM_TIMERS(2), .CNT_W(32), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .irq_block(irq_block), .irq_vec(irq_vec_a), .irqout(irqout_a)
    );

    timer_bank #(.NUM_TIMERS(4), .CNT_W(8), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .irq_block(irq_block), .irq_vec(irq_vec_b), .irqout(irqout_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ra(input int ch, input int o);
        return BASE + 32'(16 * ch + o);
    endfunction

    task automatic bus_wr(input bit b, input logic [31:0] a, input logic [31:0] d);
        if (b) begin bus_b.wr = 1'b1; bus_b.addr = a; bus_b.wdata = d; end
        else   begin bus_a.wr = 1'b1; bus_a.addr = a; bus_a.wdata = d; end
        @(posedge clk);
        #1;
        bus_a.wr = 1'b0;
        bus_b.wr = 1'b0;
    endtask

    task automatic bus_rd(input bit b, input logic [31:0] a, output logic [31:0] d);
        if (b) begin bus_b.rd = 1'b1; bus_b.addr = a; #1; d = bus_b.rdata; bus_b.rd = 1'b0; end
        else   begin bus_a.rd = 1'b1; bus_a.addr = a; #1; d = bus_a.rdata; bus_a.rd = 1'b0; end
    endtask

    // After n edges from the enabling CTRL write, the channel has seen n/(p+1) ticks.
    // Terminal happens on tick number (max - c0 + 1); afterwards the count cycles
    // through reload..max with period (max - reload + 1), or freezes in one-shot.
    task automatic model(input int w, input longint c0, input longint r, input int p,
                         input bit oneshot, input int n,
                         output longint cnt, output bit pend, output bit en);
        longint mx, t, t1;
        mx = (longint'(1) << w) - 1;
        t  = longint'(n / (p + 1));
        t1 = mx - c0 + 1;
        if (t < t1) begin
            cnt = c0 + t; pend = 1'b0; en = 1'b1;
        end else if (oneshot) begin
            cnt = r; pend = 1'b1; en = 1'b0;
        end else begin
            cnt = r + (t - t1) % (mx - r + 1); pend = 1'b1; en = 1'b1;
        end
    endtask

    logic [31:0] d;
    logic [31:0] seq3 [3];

    initial begin
        bus_a.rd = 0; bus_a.wr = 0; bus_a.addr = 0; bus_a.wdata = 0;
        bus_b.rd = 0; bus_b.wr = 0; bus_b.addr = 0; bus_b.wdata = 0;
        seq3[0] = 32'hFFFF_FFFE; seq3[1] = 32'hFFFF_FFFF; seq3[2] = 32'hFFFF_FFFD;

        // reset state
        step(); step();
        for (int ch = 0; ch < 2; ch++)
            for (int o = 0; o < 16; o += 4) begin
                bus_rd(0, ra(ch, o), d);
                check_val($sformatf("rst_a ch%0d off%0d", ch, o), d, 32'h0);
            end
        for (int ch = 0; ch < 4; ch++)
            for (int o = 0; o < 16; o += 4) begin
                bus_rd(1, ra(ch, o), d);
                check_val($sformatf("rst_b ch%0d off%0d", ch, o), d, 32'h0);
            end
        bus_rd(0, ra(2, 0), d); check_val("rst systick", d, 32'h0);
        bus_rd(0, ra(2, 4), d); check_val("rst pend_sum", d, 32'h0);
        check_val("rst irqout_a", {31'b0, irqout_a}, 32'h0);
        check_val("rst irqout_b", {31'b0, irqout_b}, 32'h0);
        check_val("rst irq_vec_b", {28'b0, irq_vec_b}, 32'h0);
        reset = 1'b0;
        step();
        bus_rd(0, ra(2, 0), d); check_val("systick first", d, 32'h1);
        bus_rd(1, ra(4, 0), d); check_val("systick_b first", d, 32'h1);

        // periodic, presc=0
        bus_wr(0, ra(0, 0), 32'hFFFF_FFFD);
        bus_wr(0, ra(0, 4), 32'hFFFF_FFFD);
        bus_wr(0, ra(0, 8), 32'h3);
        bus_rd(0, ra(0, 4), d); check_val("per cnt0", d, 32'hFFFF_FFFD);
        for (int k = 1; k <= 5; k++) begin
            step();
            bus_rd(0, ra(0, 4), d);
            check_val($sformatf("per cnt%0d", k), d, seq3[(k - 1) % 3]);
            bus_rd(0, ra(0, 12), d);
            check_val($sformatf("per pend%0d", k), d, (k >= 3) ? 32'h1 : 32'h0);
            check_val($sformatf("per irq%0d", k), {31'b0, irqout_a}, (k >= 3) ? 32'h1 : 32'h0);
        end
        // W1C lands on the second terminal edge: set wins
        bus_wr(0, ra(0, 12), 32'h1);
        bus_rd(0, ra(0, 4), d);  check_val("w1c coll cnt", d, 32'hFFFF_FFFD);
        bus_rd(0, ra(0, 12), d); check_val("w1c coll pend", d, 32'h1);
        bus_wr(0, ra(0, 12), 32'h1);
        bus_rd(0, ra(0, 12), d); check_val("w1c pend", d, 32'h0);
        check_val("w1c irqout", {31'b0, irqout_a}, 32'h0);
        step(); step();
        bus_rd(0, ra(0, 12), d); check_val("repend", d, 32'h1);
        irq_block = 1'b1; #1;
        check_val("blk irqout", {31'b0, irqout_a}, 32'h0);
        check_val("blk irq_vec", {30'b0, irq_vec_a}, 32'h1);
        irq_block = 1'b0; #1;
        check_val("unblk irqout", {31'b0, irqout_a}, 32'h1);

        // COUNT write on a tick cycle
        bus_wr(0, ra(0, 4), 32'h10);
        bus_rd(0, ra(0, 4), d); check_val("wcoll cnt", d, 32'h10);
        step();
        bus_rd(0, ra(0, 4), d); check_val("wcoll next", d, 32'h11);
        bus_wr(0, ra(0, 8), 32'h0);
        bus_wr(0, ra(0, 12), 32'h1);

        // one-shot, presc=2
        bus_wr(0, ra(1, 4), 32'hFFFF_FFFF);
        bus_wr(0, ra(1, 8), 32'h0207);
        step(); step();
        bus_rd(0, ra(1, 4), d);  check_val("os cnt pre", d, 32'hFFFF_FFFF);
        bus_rd(0, ra(1, 12), d); check_val("os pend pre", d, 32'h0);
        step();
        bus_rd(0, ra(1, 4), d);  check_val("os cnt term", d, 32'h0);
        bus_rd(0, ra(1, 8), d);  check_val("os ctrl", d, 32'h0206);
        bus_rd(0, ra(1, 12), d); check_val("os pend", d, 32'h1);
        check_val("os irqout", {31'b0, irqout_a}, 32'h1);
        repeat (4) step();
        bus_rd(0, ra(1, 4), d);  check_val("os cnt hold", d, 32'h0);
        bus_wr(0, ra(2, 4), 32'h2);
        bus_rd(0, ra(2, 4), d);  check_val("pend_sum clr", d, 32'h0);
        check_val("pend_sum irq", {31'b0, irqout_a}, 32'h0);

        // NUM_TIMERS=4, CNT_W=8
        bus_wr(1, ra(3, 0), 32'h12);
        bus_wr(1, ra(3, 4), 32'h1FE);
        bus_rd(1, ra(3, 4), d); check_val("b trunc", d, 32'hFE);
        bus_wr(1, ra(3, 8), 32'h3);
        step();
        bus_rd(1, ra(3, 4), d); check_val("b cnt ff", d, 32'hFF);
        step();
        bus_rd(1, ra(3, 4), d);         check_val("b wrap", d, 32'h12);
        bus_rd(1, BASE + 32'h44, d);    check_val("b pend_sum", d, 32'h8);
        bus_wr(1, BASE + 32'h50, 32'hFFFF_FFFF);
        bus_rd(1, BASE + 32'h50, d);    check_val("b unmapped", d, 32'h0);
        bus_wr(1, ra(3, 8), 32'h0);
        bus_wr(1, BASE + 32'h44, 32'h8);
        bus_rd(1, BASE + 32'h44, d);    check_val("b pend_sum clr", d, 32'h0);

        // randomized channel runs
        for (int it = 0; it < 24; it++) begin
            bit     b, os, ie, pend, en;
            int     w, ch, p, n;
            longint c0, r, cnt;
            b  = 1'($urandom % 2);
            w  = b ? 8 : 32;
            ch = b ? int'($urandom % 4) : int'($urandom % 2);
            p  = int'($urandom_range(0, 3));
            os = 1'($urandom % 2);
            ie = 1'($urandom % 2);
            n  = int'($urandom_range(0, 30));
            c0 = ((longint'(1) << w) - 1) - longint'($urandom_range(0, 12));
            r  = ((longint'(1) << w) - 1) - longint'($urandom_range(0, 6));
            bus_wr(b, ra(ch, 8), 32'h0);
            bus_wr(b, ra(ch, 12), 32'h1);
            bus_wr(b, ra(ch, 0), 32'(r));
            bus_wr(b, ra(ch, 4), 32'(c0));
            bus_wr(b, ra(ch, 8), (32'(p) << 8) | (32'(os) << 2) | (32'(ie) << 1) | 32'h1);
            repeat (n) step();
            model(w, c0, r, p, os, n, cnt, pend, en);
            bus_rd(b, ra(ch, 4), d);
            check_val($sformatf("rnd%0d cnt", it), d, 32'(cnt));
            bus_rd(b, ra(ch, 8), d);
            check_val($sformatf("rnd%0d ctrl", it), d,
                      (32'(p) << 8) | (32'(os) << 2) | (32'(ie) << 1) | 32'(en));
            bus_rd(b, ra(ch, 12), d);
            check_val($sformatf("rnd%0d pend", it), d, 32'(pend));
            check_val($sformatf("rnd%0d irqv", it),
                      b ? 32'(irq_vec_b[ch]) : 32'(irq_vec_a[ch]), 32'(pend & ie));
        end

        // reset mid-count
        bus_wr(0, ra(0, 4), 32'hFFFF_FFF0);
        bus_wr(0, ra(0, 8), 32'h3);
        step();
        reset = 1'b1;
        step();
        bus_rd(0, ra(0, 4), d); check_val("mid rst cnt", d, 32'h0);
        bus_rd(0, ra(0, 8), d); check_val("mid rst ctrl", d, 32'h0);
        step();
        bus_rd(0, ra(2, 0), d); check_val("mid rst systick", d, 32'h0);
        bus_rd(0, ra(0, 4), d); check_val("mid rst hold", d, 32'h0);
        check_val("mid rst irqout", {31'b0, irqout_a}, 32'h0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
